mem_bus_arbiter: RTL

- Shares the single 32-bit memory port between two requesters: requester 0 is the cpu fetch/load/store path and requester 1 is a loader/DMA engine that fills program memory.
- Each request is a single-word read or write. Round-robin arbitration is used, with a fixed, parameterised memory wait time.
- Sits between the cpu/loader and the memory model, and replaces the direct cpu-to-memory connection.

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/mem_arb_rr_pick.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_pkg
// Brief    : Shared types and constants for the memory bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr_pick
// Brief    : Combinational two-way round-robin select.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt_valid,
    output logic gnt_idx
);

    assign gnt_valid = req0 | req1;
    // prio only matters on a tie; a lone requester always wins.
    assign gnt_idx   = (req0 & req1) ? prio : req1;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin arbiter sharing one memory port between two
//            single-word requesters, with a fixed memory wait time.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = AW_DEFAULT,
    parameter int DW          = DW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_datao,
    input  logic [DW-1:0] mem_data,
    output logic          owner,
    output logic          busy
);

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    arb_state_t r_state;
    logic       r_prio;
    logic [3:0] r_count;

    logic          w_gnt_valid;
    logic          w_gnt_idx;
    logic          w_sel_rw;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    mem_arb_rr_pick u_pick (
        .req0      (req0),
        .req1      (req1),
        .prio      (r_prio),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_sel_rw    = w_gnt_idx ? rw1    : rw0;
    assign w_sel_addr  = w_gnt_idx ? addr1  : addr0;
    assign w_sel_wdata = w_gnt_idx ? wdata1 : wdata0;

    // The mem_* outputs double as the latched request, so later changes on
    // the requester side cannot disturb an access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_count     <= 4'd0;
            owner       <= 1'b0;
            busy        <= 1'b0;
            mem_en      <= 1'b0;
            mem_rw      <= RW_READ;
            mem_address <= '0;
            mem_datao   <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        owner       <= w_gnt_idx;
                        busy        <= 1'b1;
                        mem_en      <= 1'b1;
                        mem_rw      <= w_sel_rw;
                        mem_address <= w_sel_addr;
                        mem_datao   <= (w_sel_rw == RW_WRITE) ? w_sel_wdata : '0;
                        r_count     <= c_WAIT;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_count == 4'd0) begin
                        if (mem_rw == RW_READ) begin
                            if (owner) rdata1 <= mem_data;
                            else       rdata0 <= mem_data;
                        end
                        if (owner) ack1 <= 1'b1;
                        else       ack0 <= 1'b1;
                        mem_en  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                DONE: begin
                    r_prio  <= ~owner;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
